// File: rtl/bsg_arb_pkg.sv
// Shared types for the one-hot hold arbiter: mode/state encodings and mode decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package bsg_arb_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED_LO = 2'b00,
    ARB_FIXED_HI = 2'b01,
    ARB_RR       = 2'b10
  } arb_mode_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // Encoding 2'b11 has no mode of its own and behaves as round-robin.
  function automatic arb_mode_e arb_decode_mode(input logic [1:0] mode);
    arb_mode_e m;
    if (mode[1])      m = ARB_RR;
    else if (mode[0]) m = ARB_FIXED_HI;
    else              m = ARB_FIXED_LO;
    return m;
  endfunction

endpackage

// File: rtl/bsg_rotate_priority_one_hot.sv
// Circular priority pick: first set request at or after start_i, scanning up or down, one-hot plus index.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides whether the winner is accepted.
module bsg_rotate_priority_one_hot #(
  parameter int width_p    = 8,
  parameter int lg_width_p = $clog2(width_p)
) (
  input  logic [width_p-1:0]    reqs_i,
  input  logic [lg_width_p-1:0] start_i,
  input  logic                  dir_down_i,
  output logic [width_p-1:0]    grant_o,
  output logic [lg_width_p-1:0] grant_id_o
);

  function automatic logic [width_p-1:0] bit_reverse(input logic [width_p-1:0] v);
    logic [width_p-1:0] r;
    for (int i = 0; i < width_p; i++) r[i] = v[width_p-1-i];
    return r;
  endfunction

  logic [width_p-1:0]    req_dir;
  logic [lg_width_p-1:0] start_dir;
  logic [2*width_p-1:0]  rot_r_wide;
  logic [width_p-1:0]    rot;
  logic [width_p-1:0]    rot_hit;
  logic [2*width_p-1:0]  rot_l_wide;
  logic [width_p-1:0]    back;

  // Downward scans reuse the upward datapath on a bit-reversed vector; rotate start to bit 0,
  // keep the lowest set bit, rotate back.
  always_comb begin
    req_dir    = dir_down_i ? bit_reverse(reqs_i) : reqs_i;
    start_dir  = dir_down_i ? (lg_width_p'(width_p - 1) - start_i) : start_i;
    rot_r_wide = {req_dir, req_dir} >> start_dir;
    rot        = rot_r_wide[width_p-1:0];
    rot_hit    = rot & (~rot + width_p'(1));
    rot_l_wide = {rot_hit, rot_hit} << start_dir;
    back       = rot_l_wide[2*width_p-1:width_p];
    grant_o    = dir_down_i ? bit_reverse(back) : back;
  end

  // Encode the one-hot winner; all-zero grant encodes as index 0.
  always_comb begin
    grant_id_o = '0;
    for (int i = 0; i < width_p; i++) begin
      if (grant_o[i]) grant_id_o = lg_width_p'(i);
    end
  end

endmodule

// File: rtl/bsg_arb_one_hot_hold.sv
// Multi-mode one-hot arbiter (fixed lo->hi, fixed hi->lo, round-robin) that holds an unaccepted grant.
// Latency: 0 cycles from reqs_i to grants_o in IDLE; a held grant persists until yumi_i or request withdrawal.
// Backpressure: yumi_i=0 locks the current winner; optional anti-starvation under BSG_ARB_STARVE_GUARD_EN.
module bsg_arb_one_hot_hold
  import bsg_arb_pkg::*;
#(
  parameter int width_p      = 8,
  parameter int lg_width_p   = $clog2(width_p),
  parameter int starve_max_p = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [width_p-1:0]    reqs_i,
  input  logic [1:0]            mode_i,
  output logic [width_p-1:0]    grants_o,
  output logic [lg_width_p-1:0] grant_id_o,
  output logic                  v_o,
  input  logic                  yumi_i
);

  function automatic logic [lg_width_p-1:0] onehot_to_id(input logic [width_p-1:0] oh);
    logic [lg_width_p-1:0] id;
    id = '0;
    for (int i = 0; i < width_p; i++) begin
      if (oh[i]) id = lg_width_p'(i);
    end
    return id;
  endfunction

  arb_state_e            state_q, state_d;
  logic [width_p-1:0]    locked_q, locked_d;
  logic [lg_width_p-1:0] rr_last_q, rr_last_d;
  arb_mode_e             hold_mode_q, hold_mode_d;

  arb_mode_e             mode_dec;
  logic [lg_width_p-1:0] scan_start;
  logic                  scan_down;
  logic [width_p-1:0]    scan_grant;
  logic [lg_width_p-1:0] scan_id;
  logic [width_p-1:0]    starved;
  logic [width_p-1:0]    starve_oh;
  logic [width_p-1:0]    idle_grant;
  logic [lg_width_p-1:0] idle_id;

  // Pick the scan origin and direction for the requested mode.
  always_comb begin
    mode_dec   = arb_decode_mode(mode_i);
    scan_down  = 1'b0;
    scan_start = '0;
    case (mode_dec)
      ARB_FIXED_HI: begin
        scan_down  = 1'b1;
        scan_start = lg_width_p'(width_p - 1);
      end
      ARB_RR: begin
        scan_start = (rr_last_q == lg_width_p'(width_p - 1)) ? '0 : rr_last_q + lg_width_p'(1);
      end
      default: scan_start = '0;
    endcase
  end

  bsg_rotate_priority_one_hot #(
    .width_p   (width_p),
    .lg_width_p(lg_width_p)
  ) u_scan (
    .reqs_i    (reqs_i),
    .start_i   (scan_start),
    .dir_down_i(scan_down),
    .grant_o   (scan_grant),
    .grant_id_o(scan_id)
  );

`ifdef BSG_ARB_STARVE_GUARD_EN
  localparam int cnt_w_lp = $clog2(starve_max_p + 1);

  logic [cnt_w_lp-1:0] starve_cnt_q [width_p];
  logic [cnt_w_lp-1:0] starve_cnt_d [width_p];
  logic [width_p-1:0]  accepted;

  // Count consecutive un-accepted request cycles per requester, saturating at the threshold.
  always_comb begin
    accepted = (v_o && yumi_i) ? grants_o : '0;
    for (int k = 0; k < width_p; k++) begin
      starved[k] = reqs_i[k] && (starve_cnt_q[k] == cnt_w_lp'(starve_max_p));
      if (!reqs_i[k] || accepted[k])                      starve_cnt_d[k] = '0;
      else if (starve_cnt_q[k] != cnt_w_lp'(starve_max_p)) starve_cnt_d[k] = starve_cnt_q[k] + cnt_w_lp'(1);
      else                                                starve_cnt_d[k] = starve_cnt_q[k];
    end
  end

  // Starvation counters register.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < width_p; k++) begin
      if (!reset_n_i) starve_cnt_q[k] <= '0;
      else            starve_cnt_q[k] <= starve_cnt_d[k];
    end
  end
`else
  localparam int unused_starve_max_lp = starve_max_p;
  assign starved = '0;
`endif

  // A starved requester overrides the mode; lowest index first among the starved.
  always_comb begin
    starve_oh = starved & (~starved + width_p'(1));
    if (|starved) begin
      idle_grant = starve_oh;
      idle_id    = onehot_to_id(starve_oh);
    end else begin
      idle_grant = scan_grant;
      idle_id    = scan_id;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= ARB_IDLE;
    else            state_q <= state_d;
  end

  // Lock, round-robin pointer and held-mode registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      locked_q    <= '0;
      rr_last_q   <= lg_width_p'(width_p - 1);
      hold_mode_q <= ARB_FIXED_LO;
    end else begin
      locked_q    <= locked_d;
      rr_last_q   <= rr_last_d;
      hold_mode_q <= hold_mode_d;
    end
  end

  // Next state: lock an unaccepted winner, release on accept or withdrawal; advance RR only on accepts.
  always_comb begin
    state_d     = state_q;
    locked_d    = locked_q;
    rr_last_d   = rr_last_q;
    hold_mode_d = hold_mode_q;
    case (state_q)
      ARB_IDLE: begin
        if (v_o) begin
          if (yumi_i) begin
            if (mode_dec == ARB_RR) rr_last_d = idle_id;
          end else begin
            state_d     = ARB_HOLD;
            locked_d    = idle_grant;
            hold_mode_d = mode_dec;
          end
        end
      end
      ARB_HOLD: begin
        if (v_o && yumi_i) begin
          state_d  = ARB_IDLE;
          locked_d = '0;
          if (hold_mode_q == ARB_RR) rr_last_d = onehot_to_id(locked_q);
        end else if (!v_o) begin
          state_d  = ARB_IDLE;
          locked_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: live pick in IDLE, frozen lock in HOLD, all zero while reset is asserted.
  always_comb begin
    grants_o   = '0;
    grant_id_o = '0;
    v_o        = 1'b0;
    if (reset_n_i) begin
      if (state_q == ARB_HOLD) begin
        grants_o   = locked_q;
        grant_id_o = onehot_to_id(locked_q);
        v_o        = |(locked_q & reqs_i);
      end else begin
        grants_o   = idle_grant;
        grant_id_o = idle_id;
        v_o        = |reqs_i;
      end
    end
  end

  // A yumi without a valid grant is a consumer protocol violation.
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_arb_one_hot_hold.sv
// Directed bench for bsg_arb_one_hot_hold at width_p=4.
// Latency: checks combinational outputs mid-cycle after driving inputs just past the rising edge.
// Backpressure: exercises hold, withdrawal and accept paths via yumi_i.
module tb_bsg_arb_one_hot_hold;

  localparam int W  = 4;
  localparam int LW = 2;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [W-1:0]  reqs_i;
  logic [1:0]    mode_i;
  logic          yumi_i;
  logic [W-1:0]  grants_o;
  logic [LW-1:0] grant_id_o;
  logic          v_o;

  int n_checks = 0;
  int n_errors = 0;

  bsg_arb_one_hot_hold #(
    .width_p     (W),
    .lg_width_p  (LW),
    .starve_max_p(3)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .reqs_i    (reqs_i),
    .mode_i    (mode_i),
    .grants_o  (grants_o),
    .grant_id_o(grant_id_o),
    .v_o       (v_o),
    .yumi_i    (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs at the falling edge, then advance past the next rising edge.
  task automatic cycle(input string tag, input logic rn, input logic [1:0] m, input logic [W-1:0] r,
                       input logic y, input logic [W-1:0] eg, input int eid, input logic ev);
    reset_n_i = rn;
    mode_i    = m;
    reqs_i    = r;
    yumi_i    = y;
    @(negedge clk_i);
    check_val({tag, ".grants"}, 32'(grants_o), 32'(eg));
    check_val({tag, ".id"}, 32'(grant_id_o), 32'(eid));
    check_val({tag, ".v"}, 32'(v_o), 32'(ev));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_n_i = 1'b0;
    reqs_i    = 4'b1111;
    mode_i    = 2'b00;
    yumi_i    = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset held with all requests: outputs stay zero.
    for (int i = 0; i < 3; i++) cycle($sformatf("rst%0d", i), 1'b0, 2'b00, 4'b1111, 1'b0, 4'b0000, 0, 1'b0);

    // First cycle after release, fixed lo->hi.
    cycle("rel_lo", 1'b1, 2'b00, 4'b1111, 1'b1, 4'b0001, 0, 1'b1);
    // Fixed hi->lo.
    cycle("fix_hi", 1'b1, 2'b01, 4'b0110, 1'b1, 4'b0100, 2, 1'b1);
    // Round-robin, all requesting: rotates 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      cycle($sformatf("rr%0d", i), 1'b1, 2'b10, 4'b1111, 1'b1, 4'(1 << (i % 4)), i % 4, 1'b1);

    // Hold on requester 1; mode change during HOLD must not matter.
    cycle("hold0", 1'b1, 2'b00, 4'b1010, 1'b0, 4'b0010, 1, 1'b1);
    cycle("hold1", 1'b1, 2'b01, 4'b1010, 1'b0, 4'b0010, 1, 1'b1);
    cycle("hold2", 1'b1, 2'b01, 4'b1010, 1'b0, 4'b0010, 1, 1'b1);
    cycle("hold_acc", 1'b1, 2'b00, 4'b0011, 1'b1, 4'b0010, 1, 1'b1);
    cycle("post_hold", 1'b1, 2'b00, 4'b0011, 1'b1, 4'b0001, 0, 1'b1);

    // Round-robin hold on requester 2, then withdrawal: pointer (last=0) unchanged.
    cycle("wd_lock", 1'b1, 2'b10, 4'b0100, 1'b0, 4'b0100, 2, 1'b1);
    cycle("wd_drop", 1'b1, 2'b10, 4'b1011, 1'b0, 4'b0100, 2, 1'b0);
    cycle("wd_idle", 1'b1, 2'b10, 4'b1111, 1'b1, 4'b0010, 1, 1'b1);

    // Round-robin accept from HOLD uses the mode latched at lock time.
    cycle("rrh_lock", 1'b1, 2'b10, 4'b1001, 1'b0, 4'b1000, 3, 1'b1);
    cycle("rrh_acc", 1'b1, 2'b00, 4'b1001, 1'b1, 4'b1000, 3, 1'b1);
    cycle("rrh_next", 1'b1, 2'b10, 4'b1111, 1'b1, 4'b0001, 0, 1'b1);

    // Reset during HOLD discards the lock and restores the pointer.
    cycle("rsth_lock", 1'b1, 2'b10, 4'b0100, 1'b0, 4'b0100, 2, 1'b1);
    cycle("rsth_rst", 1'b0, 2'b10, 4'b1111, 1'b0, 4'b0000, 0, 1'b0);
    cycle("rsth_idle", 1'b1, 2'b10, 4'b1111, 1'b1, 4'b0001, 0, 1'b1);

    // Single requester wins in every mode, including encoding 11.
    for (int m = 0; m < 4; m++)
      cycle($sformatf("single_m%0d", m), 1'b1, 2'(m), 4'b0100, 1'b1, 4'b0100, 2, 1'b1);

    // No requests: nothing valid.
    cycle("none", 1'b1, 2'b00, 4'b0000, 1'b0, 4'b0000, 0, 1'b0);

`ifdef BSG_ARB_STARVE_GUARD_EN
    // Starvation guard with threshold 3: requester 3 forced in on the 4th cycle.
    cycle("stv_rst", 1'b0, 2'b00, 4'b0000, 1'b0, 4'b0000, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle($sformatf("stv%0d", i), 1'b1, 2'b00, 4'b1001, 1'b1, 4'b0001, 0, 1'b1);
    cycle("stv_force", 1'b1, 2'b00, 4'b1001, 1'b1, 4'b1000, 3, 1'b1);
    cycle("stv_resume", 1'b1, 2'b00, 4'b1001, 1'b1, 4'b0001, 0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
